// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, default bit timing and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

  // 50 MHz system clock at 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for the idle-high serial line
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - UART receiver: mid-bit sampling, optional even parity, one-byte holding register
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);

  uart_state_e state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        bad, bad_n;
  logic        line_s;
  logic [1:0]  warm;
  logic        seen_high;
  logic        deliver, frame_hit, parity_hit;

  uart_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (line_s)
  );

  assign rx_busy = (state != ST_IDLE);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    shreg_n    = shreg;
    bad_n      = bad;
    deliver    = 1'b0;
    frame_hit  = 1'b0;
    parity_hit = 1'b0;
    case (state)
      // warm masks the synchronizer's forced-high reset value; a line that
      // has never been seen high since reset is a break, not a start bit
      ST_IDLE: begin
        if (warm[1] && !line_s) begin
          if (seen_high) begin
            state_n = ST_START;
            cnt_n   = HALF_CNT;
          end else begin
            state_n = ST_WAIT_IDLE;
          end
        end
      end
      ST_START: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else if (!line_s) begin
          state_n = ST_DATA;
          cnt_n   = FULL_CNT;
          bit_n   = 3'd0;
          bad_n   = 1'b0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          shreg_n = {line_s, shreg[7:1]};
          cnt_n   = FULL_CNT;
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          bad_n   = (line_s != even_parity(shreg));
          cnt_n   = FULL_CNT;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          cnt_n = 16'd0;
          if (!line_s) begin
            frame_hit = 1'b1;
            state_n   = ST_WAIT_IDLE;
          end else if (bad) begin
            parity_hit = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            deliver = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (line_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cnt            <= 16'd0;
      bit_idx        <= 3'd0;
      shreg          <= 8'h00;
      bad            <= 1'b0;
      warm           <= 2'b00;
      seen_high      <= 1'b0;
      data_out       <= 8'h00;
      data_out_valid <= 1'b0;
      frame_err      <= 1'b0;
      parity_err     <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      bad        <= bad_n;
      warm       <= {warm[0], 1'b1};
      if (warm[1] && line_s) seen_high <= 1'b1;
      frame_err  <= frame_hit;
      parity_err <= parity_hit;
      overrun    <= deliver && data_out_valid && !rx_ready;
      if (deliver && (!data_out_valid || rx_ready)) begin
        data_out       <= shreg;
        data_out_valid <= 1'b1;
      end else if (data_out_valid && rx_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed and randomized checks of uart_rx_deframer against a frame-level model
module tb_uart_rx_deframer;

  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx_ready, sline0, sline1;
  logic [7:0] dout0, dout1;
  logic       vld0, vld1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
    .clk(clk), .rst(rst), .serial_in(sline0), .data_out(dout0),
    .data_out_valid(vld0), .rx_ready(rx_ready), .frame_err(fe0),
    .parity_err(pe0), .overrun(ov0), .rx_busy(busy0)
  );

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .serial_in(sline1), .data_out(dout1),
    .data_out_valid(vld1), .rx_ready(rx_ready), .frame_err(fe1),
    .parity_err(pe1), .overrun(ov1), .rx_busy(busy1)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] got0[$];
  logic [7:0] got1[$];
  logic [7:0] expq[$];
  int vc0 = 0, fc0 = 0, pc0 = 0, oc0 = 0, bz0 = 0;
  int vc1 = 0, fc1 = 0, pc1 = 0, oc1 = 0;
  int b_got0, b_vc0, b_fc0, b_pc0, b_oc0, b_bz0;
  int b_got1, b_fc1, b_pc1, b_oc1;

  // Observer: record every accepted byte and every flag pulse
  always @(negedge clk) begin
    if (vld0 && rx_ready) got0.push_back(dout0);
    if (vld1 && rx_ready) got1.push_back(dout1);
    if (vld0)  vc0++;
    if (fe0)   fc0++;
    if (pe0)   pc0++;
    if (ov0)   oc0++;
    if (busy0) bz0++;
    if (vld1)  vc1++;
    if (fe1)   fc1++;
    if (pe1)   pc1++;
    if (ov1)   oc1++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input logic v);
    if (inst == 0) sline0 = v;
    else           sline1 = v;
  endtask

  task automatic send(input int inst, input logic [7:0] b, input logic with_par,
                      input logic par, input logic stop, input int stop_len);
    drive(inst, 1'b0);
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(inst, b[i]);
      cyc(CPB);
    end
    if (with_par) begin
      drive(inst, par);
      cyc(CPB);
    end
    drive(inst, stop);
    cyc(stop_len);
    drive(inst, 1'b1);
  endtask

  task automatic mark();
    b_got0 = got0.size(); b_vc0 = vc0; b_fc0 = fc0; b_pc0 = pc0; b_oc0 = oc0; b_bz0 = bz0;
    b_got1 = got1.size(); b_fc1 = fc1; b_pc1 = pc1; b_oc1 = oc1;
    expq.delete();
  endtask

  task automatic check_rx(input string tag, input int inst, input int efe, input int epe, input int eov);
    int n;
    n = (inst == 0) ? got0.size() - b_got0 : got1.size() - b_got1;
    check({tag, "_count"}, n, expq.size());
    for (int i = 0; i < expq.size() && i < n; i++) begin
      if (inst == 0) check($sformatf("%s_byte%0d", tag, i), 32'(got0[b_got0 + i]), 32'(expq[i]));
      else           check($sformatf("%s_byte%0d", tag, i), 32'(got1[b_got1 + i]), 32'(expq[i]));
    end
    check({tag, "_frame_err"}, (inst == 0) ? fc0 - b_fc0 : fc1 - b_fc1, efe);
    check({tag, "_parity_err"}, (inst == 0) ? pc0 - b_pc0 : pc1 - b_pc1, epe);
    check({tag, "_overrun"}, (inst == 0) ? oc0 - b_oc0 : oc1 - b_oc1, eov);
  endtask

  task automatic check_reset(input string tag, input int inst);
    if (inst == 0) begin
      check({tag, "_dout0"}, 32'(dout0), 32'h00);
      check({tag, "_valid0"}, 32'(vld0), 32'd0);
      check({tag, "_flags0"}, 32'({fe0, pe0, ov0}), 32'd0);
      check({tag, "_busy0"}, 32'(busy0), 32'd0);
    end else begin
      check({tag, "_dout1"}, 32'(dout1), 32'h00);
      check({tag, "_valid1"}, 32'(vld1), 32'd0);
      check({tag, "_flags1"}, 32'({fe1, pe1, ov1}), 32'd0);
      check({tag, "_busy1"}, 32'(busy1), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] b;
    logic       stop_ok, par_ok;
    int         efe, epe;

    rst = 1'b0; rx_ready = 1'b1; sline0 = 1'b1; sline1 = 1'b1;
    cyc(3);
    check_reset("reset", 0);
    check_reset("reset", 1);
    rst = 1'b1;
    cyc(10);

    // Single 8N1 frame consumed immediately
    mark();
    send(0, 8'hA5, 1'b0, 1'b0, 1'b1, CPB);
    cyc(20);
    expq.push_back(8'hA5);
    check_rx("a5", 0, 0, 0, 0);
    check("a5_valid_cycles", vc0 - b_vc0, 1);

    // Two frames back to back into a stalled consumer
    mark();
    rx_ready = 1'b0;
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1, CPB);
    send(0, 8'hC3, 1'b0, 1'b0, 1'b1, CPB);
    cyc(20);
    check("ovr_held_byte", 32'(dout0), 32'h3C);
    check("ovr_held_valid", 32'(vld0), 32'd1);
    rx_ready = 1'b1;
    cyc(1);
    check("ovr_valid_cleared", 32'(vld0), 32'd0);
    expq.push_back(8'h3C);
    check_rx("ovr", 0, 0, 0, 1);

    // Stop bit held low (break), then a clean frame
    mark();
    send(0, 8'h55, 1'b0, 1'b0, 1'b0, 40);
    cyc(20);
    check("break_no_valid", vc0 - b_vc0, 0);
    send(0, 8'h12, 1'b0, 1'b0, 1'b1, CPB);
    cyc(20);
    expq.push_back(8'h12);
    check_rx("break", 0, 1, 0, 0);

    // Short low glitch on an idle line
    mark();
    drive(0, 1'b0);
    cyc(2);
    drive(0, 1'b1);
    cyc(30);
    check("glitch_was_busy", 32'((bz0 - b_bz0) > 0), 32'd1);
    check("glitch_idle", 32'(busy0), 32'd0);
    check("glitch_no_valid", vc0 - b_vc0, 0);
    check_rx("glitch", 0, 0, 0, 0);

    // Even parity: 8'h07 has three ones, so the correct parity bit is 1
    mark();
    send(1, 8'h07, 1'b1, 1'b0, 1'b1, CPB);
    cyc(20);
    check_rx("par_bad", 1, 0, 1, 0);
    mark();
    send(1, 8'h07, 1'b1, 1'b1, 1'b1, CPB);
    cyc(20);
    expq.push_back(8'h07);
    check_rx("par_good", 1, 0, 0, 0);

    // Reset in the middle of a frame with the line left low afterwards
    mark();
    drive(0, 1'b0);
    cyc(CPB);
    drive(0, 1'b1);
    cyc(2 * CPB);
    drive(0, 1'b0);
    rst = 1'b0;
    cyc(3);
    check_reset("midrst", 0);
    rst = 1'b1;
    cyc(50);
    check("midrst_wait_busy", 32'(busy0), 32'd1);
    check("midrst_no_valid", vc0 - b_vc0, 0);
    drive(0, 1'b1);
    cyc(20);
    check("midrst_idle", 32'(busy0), 32'd0);
    send(0, 8'h81, 1'b0, 1'b0, 1'b1, CPB);
    cyc(20);
    expq.push_back(8'h81);
    check_rx("midrst", 0, 0, 0, 0);

    // Random frames, some back to back, some with bad stop or parity
    for (int inst = 0; inst < 2; inst++) begin
      mark();
      efe = 0;
      epe = 0;
      for (int k = 0; k < 24; k++) begin
        b       = 8'($urandom);
        stop_ok = ($urandom_range(0, 4) != 0);
        par_ok  = ($urandom_range(0, 3) != 0);
        send(inst, b, inst == 1, (^b) ^ !par_ok, stop_ok, CPB);
        if (!stop_ok)                 efe++;
        else if (inst == 1 && !par_ok) epe++;
        else                          expq.push_back(b);
        if (!stop_ok)                cyc(CPB);
        else if ($urandom_range(0, 1) != 0) cyc($urandom_range(1, 20));
      end
      cyc(40);
      check_rx($sformatf("rand%0d", inst), inst, efe, epe, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
